vga_timing_gen: RTL
===================

# vga_timing_gen

Free-running VGA raster timing generator: produces the pixel position (POS_X, POS_Y), the active-area qualifier DISPLAY_EN and the HSYNC/VSYNC pins. It drives the position inputs of the pixel-to-tile mapper and the colour path, so every downstream block sees one coherent, registered raster coordinate per pixel. Defaults are 1280x1024@60 (108 MHz pixel rate).

## Interface
Parameters:
- H_VIS, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, horizontal sync width (pixels)
- H_BP, 248, horizontal back porch (pixels)
- V_VIS, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines)
- H_POL, 1, HSYNC active level
- V_POL, 1, VSYNC active level

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- PIX_EN  in  1  pixel-rate enable; raster advances only on cycles where it is high
- POS_X  out  11  current horizontal count, 0..H_TOTAL-1
- POS_Y  out  11  current vertical count, 0..V_TOTAL-1
- DISPLAY_EN  out  1  high when POS_X < H_VIS and POS_Y < V_VIS
- HSYNC  out  1  horizontal sync, level H_POL when active
- VSYNC  out  1  vertical sync, level V_POL when active
- LINE_START  out  1  one-CLK pulse when POS_X advances to 0
- FRAME_START  out  1  one-CLK pulse when (POS_X, POS_Y) advances to (0, 0)
- FRAME_CNT  out  8  frames since reset (only with VGA_FRAME_CNT_EN)

## Operation
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1688); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (1066). Both must be ≤ 2048.
- When PIX_EN is high: POS_X increments. At H_TOTAL-1 it wraps to 0 and POS_Y increments. At POS_Y = V_TOTAL-1 together with POS_X = H_TOTAL-1, both wrap to 0.
- When PIX_EN is low: all counters and the level outputs hold. LINE_START and FRAME_START are 0.
- HSYNC is active for POS_X in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]; default 1328..1439.
- VSYNC is active for POS_Y in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]; default 1025..1027. VSYNC changes only together with a POS_Y change.
- All outputs are flops decoded from next-state counter values. On every cycle, DISPLAY_EN, HSYNC, VSYNC and the pulses describe the POS_X/POS_Y presented in that same cycle, with zero skew.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - POS_X = H_TOTAL-1, POS_Y = V_TOTAL-1
  - DISPLAY_EN = 0, HSYNC = !H_POL, VSYNC = !V_POL
  - LINE_START = 0, FRAME_START = 0, FRAME_CNT = 0
  - The first PIX_EN after reset release moves to (0,0) with LINE_START = FRAME_START = 1.

## Timing
- Latency: one CLK from a PIX_EN-high edge to the new position and its qualifiers.
- LINE_START and FRAME_START are high for exactly one CLK: the cycle after the advancing edge. FRAME_START implies LINE_START.
- With PIX_EN tied high: line period is 1688 CLK and frame period is 1,799,408 CLK (defaults).
- Reset deassertion is assumed synchronised externally. The block does not re-time RST_N.

## Configuration
- VGA_FRAME_CNT_EN defined:
  - FRAME_CNT port exists.
  - It increments modulo 256 in the same cycle FRAME_START is asserted.
  - The first frame after reset reads 1.
- VGA_FRAME_CNT_EN undefined: FRAME_CNT port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then PIX_EN = 1 constantly:
  - First cycle gives POS = (0,0), DISPLAY_EN = 1, LINE_START = FRAME_START = 1.
  - POS_X reaches 1687 and then returns to 0, with POS_Y = 1 and LINE_START = 1.
- Horizontal decode on line 0:
  - DISPLAY_EN falls at POS_X = 1280.
  - HSYNC is high for POS_X 1328..1439, exactly 112 pixels.
  - DISPLAY_EN rises again at the next POS_X = 0.
- Full frame:
  - VSYNC is high only on lines 1025..1027.
  - DISPLAY_EN = 0 for all of lines 1024..1065.
  - FRAME_START recurs after exactly 1,799,408 CLK.
- PIX_EN toggling 1/0 (half rate):
  - Counters advance every second CLK.
  - Outputs hold during the PIX_EN-low cycles.
  - Pulses last 1 CLK.
  - Line period is 3376 CLK.
- Assert RST_N low at POS = (1350, 500), during HSYNC:
  - Outputs immediately go to their reset values: HSYNC = 0, POS = (1687, 1065).
  - After release, the raster restarts at (0,0).
- With VGA_FRAME_CNT_EN: run 257 frames; FRAME_CNT reads 1 in frame 1, 255 in frame 255, then wraps to 0 then 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the VGA timing generator and its consumers
//
// Signals:
//   pix_en      pixel-rate enable into the generator
//   pos_x/pos_y registered raster coordinate (11 bits each)
//   display_en  active-area qualifier for pos_x/pos_y
//   hsync/vsync sync pins, already at their configured polarity
//   line_start  one-clock pulse on the cycle pos_x becomes 0
//   frame_start one-clock pulse on the cycle the raster becomes (0,0)
//   frame_cnt   frames since reset (only when VGA_FRAME_CNT_EN is defined)
//
// Modports: master = timing generator, slave = raster consumer.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        display_en;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frame_cnt;

  modport master (
    input  pix_en,
    output pos_x, pos_y, display_en, hsync, vsync, line_start, frame_start, frame_cnt
  );
  modport slave (
    output pix_en,
    input  pos_x, pos_y, display_en, hsync, vsync, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  pix_en,
    output pos_x, pos_y, display_en, hsync, vsync, line_start, frame_start
  );
  modport slave (
    output pix_en,
    input  pos_x, pos_y, display_en, hsync, vsync, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator (default 1280x1024@60)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (deassertion synchronised externally)
//   vga    vga_timing_gen_if.master: pix_en in; pos_x, pos_y, display_en,
//          hsync, vsync, line_start, frame_start (and frame_cnt) out
//
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame counter.
//
// Every output is a flop loaded from the next-state counter values, so the
// qualifiers and pulses always describe the coordinate presented alongside
// them. Reset parks the raster on its last pixel, so the first enabled cycle
// wraps to (0,0) and raises both start pulses.
module vga_timing_gen #(
  parameter int H_VIS  = 1280,
  parameter int H_FP   = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP   = 248,
  parameter int V_VIS  = 1024,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 38,
  parameter bit H_POL  = 1'b1,
  parameter bit V_POL  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_VIS);
  localparam logic [10:0] V_ACT    = 11'(V_VIS);
  localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
    $error("vga_timing_gen: raster totals exceed the 11-bit counters");
  end

  logic [10:0] pos_x_q, pos_y_q;
  logic [10:0] x_nxt, y_nxt;
  logic        wrap_x, wrap_y;
  logic        display_en_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  always_comb begin
    wrap_x = (pos_x_q == H_LAST);
    wrap_y = (pos_y_q == V_LAST);
    x_nxt  = wrap_x ? 11'd0 : pos_x_q + 11'd1;
    y_nxt  = pos_y_q;
    if (wrap_x) begin
      y_nxt = wrap_y ? 11'd0 : pos_y_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q       <= H_LAST;
      pos_y_q       <= V_LAST;
      display_en_q  <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Pulses are single-cycle; levels hold unless the raster advances.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (vga.pix_en) begin
        pos_x_q       <= x_nxt;
        pos_y_q       <= y_nxt;
        display_en_q  <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
        hsync_q       <= ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) ? H_POL : ~H_POL;
        // y_nxt only moves on a line wrap, so vsync can only change with pos_y.
        vsync_q       <= ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) ? V_POL : ~V_POL;
        line_start_q  <= wrap_x;
        frame_start_q <= wrap_x && wrap_y;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts on the same edge that raises frame_start, so frame 1 reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (vga.pix_en && wrap_x && wrap_y) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pos_x       = pos_x_q;
  assign vga.pos_y       = pos_y_q;
  assign vga.display_en  = display_en_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
